// File: rtl/puf_pkg.sv
// -----------------------------------------------------------------------------
// puf_pkg
//   Shared definitions for the SR-latch PUF sampler:
//     - puf_state_t : controller FSM states
//     - SYNC_DEPTH  : number of synchroniser flops on the latch Q inputs
//     - count_width : bits needed to hold values 0..max_val
// -----------------------------------------------------------------------------
package puf_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EXCITE  = 3'd1,
        RELEASE = 3'd2,
        SAMPLE  = 3'd3,
        DONE    = 3'd4
    } puf_state_t;

    localparam int SYNC_DEPTH = 2;

    // Width of a counter that must reach max_val; never narrower than 1 bit.
    function automatic int count_width(input int max_val);
        if (max_val < 1) begin
            return 1;
        end else begin
            return $clog2(max_val + 1);
        end
    endfunction

endpackage

// File: rtl/puf_vote_counter.sv
// -----------------------------------------------------------------------------
// puf_vote_counter
//   Per-cell vote accumulator. Counts how many trials a latch resolved to 1.
//   majority and unanimous are taken from the count *including* the current
//   cycle's increment, so the controller can register the final verdict on
//   the same edge that records the last sample.
//
//   Ports:
//     clk, rst    clock, asynchronous active-high reset
//     clear       synchronous clear at the start of a response
//     inc_en      sample strobe (one per trial)
//     sample_bit  synchronised latch Q for this cell
//     count       accumulated ones (registered)
//     majority    count > TRIALS/2
//     unanimous   count == 0 or count == TRIALS (PUF_STABILITY_FLAG_EN only)
// -----------------------------------------------------------------------------
module puf_vote_counter
    import puf_pkg::*;
#(
    parameter int TRIALS = 5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clear,
    input  logic                            inc_en,
    input  logic                            sample_bit,
    output logic [count_width(TRIALS)-1:0]  count,
    output logic                            majority
`ifdef PUF_STABILITY_FLAG_EN
    ,output logic                           unanimous
`endif
);

    localparam int CW = count_width(TRIALS);

    logic [CW-1:0] count_nxt;

    // Next count: clear wins; at most TRIALS increments per response, so no wrap.
    always_comb begin
        count_nxt = count;
        if (clear) begin
            count_nxt = '0;
        end else if (inc_en && sample_bit) begin
            count_nxt = count + CW'(1);
        end else begin
            count_nxt = count;
        end
    end

    // Vote count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

    assign majority = (count_nxt > CW'(TRIALS / 2));

`ifdef PUF_STABILITY_FLAG_EN
    assign unanimous = (count_nxt == CW'(0)) || (count_nxt == CW'(TRIALS));
`endif

endmodule

// File: rtl/sr_puf_sampler.sv
// -----------------------------------------------------------------------------
// sr_puf_sampler
//   Controller for N cross-coupled NAND SR-latch PUF cells. Each trial forces
//   every latch to Q=Qn=1 (S=R=0), releases all S/R lines on one edge, lets the
//   latches settle and then samples the synchronised Q. Each bit is
//   majority-voted over TRIALS trials and presented on a valid/ready port.
//
//   Optional feature macro: PUF_STABILITY_FLAG_EN adds the 'stable' output
//   (per-bit unanimity across all trials, valid with resp_valid).
//
//   Ports:
//     clk, rst    clock, asynchronous active-high reset
//     start       request one response (accepted only in IDLE)
//     busy        high from accept until the response handshake
//     cell_s      S drive to latches (0 forces Q=1)
//     cell_r      R drive to latches (0 forces Qn=1)
//     cell_q      asynchronous latch Q outputs
//     resp        majority-voted response
//     resp_valid  response valid, held until resp_ready
//     resp_ready  consumer accepts resp
//     stable      per-bit unanimity flag (PUF_STABILITY_FLAG_EN only)
// -----------------------------------------------------------------------------
module sr_puf_sampler
    import puf_pkg::*;
#(
    parameter int N          = 4,
    parameter int TRIALS     = 5,
    parameter int RST_CYC    = 2,
    parameter int SETTLE_CYC = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         busy,
    output logic [N-1:0] cell_s,
    output logic [N-1:0] cell_r,
    input  logic [N-1:0] cell_q,
    output logic [N-1:0] resp,
    output logic         resp_valid,
    input  logic         resp_ready
`ifdef PUF_STABILITY_FLAG_EN
    ,output logic [N-1:0] stable
`endif
);

    localparam int CW = count_width(TRIALS);
    localparam int TW = count_width(TRIALS);
    localparam int PW = count_width((RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC);

    puf_state_t    state;
    puf_state_t    state_nxt;
    logic [PW-1:0] phase_cnt;
    logic [PW-1:0] phase_nxt;
    logic [TW-1:0] trial_cnt;
    logic [TW-1:0] trial_nxt;
    logic          clear_votes;
    logic          inc_votes;
    logic          last_sample;
    logic          handshake;
    logic          drive_sr;
    logic [N-1:0]  sync_q [SYNC_DEPTH];
    logic [N-1:0]  majority_bits;
    logic [CW-1:0] vote_count_unused [N];
`ifdef PUF_STABILITY_FLAG_EN
    logic [N-1:0]  unanimous_bits;
`endif

    // FSM next-state, phase/trial counter and vote strobe decode.
    always_comb begin
        state_nxt   = state;
        phase_nxt   = phase_cnt;
        trial_nxt   = trial_cnt;
        clear_votes = 1'b0;
        inc_votes   = 1'b0;
        last_sample = 1'b0;
        handshake   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = EXCITE;
                    phase_nxt   = '0;
                    trial_nxt   = '0;
                    clear_votes = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            EXCITE: begin
                if (phase_cnt == PW'(RST_CYC - 1)) begin
                    state_nxt = RELEASE;
                    phase_nxt = '0;
                end else begin
                    phase_nxt = phase_cnt + PW'(1);
                end
            end
            RELEASE: begin
                if (phase_cnt == PW'(SETTLE_CYC - 1)) begin
                    state_nxt = SAMPLE;
                    phase_nxt = '0;
                end else begin
                    phase_nxt = phase_cnt + PW'(1);
                end
            end
            SAMPLE: begin
                inc_votes = 1'b1;
                if (trial_cnt == TW'(TRIALS - 1)) begin
                    state_nxt   = DONE;
                    last_sample = 1'b1;
                end else begin
                    state_nxt = EXCITE;
                    trial_nxt = trial_cnt + TW'(1);
                end
            end
            DONE: begin
                if (resp_valid && resp_ready) begin
                    state_nxt = IDLE;
                    handshake = 1'b1;
                end else begin
                    state_nxt = DONE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // S and R are released together and stay high through the sample cycle.
    assign drive_sr = (state_nxt == RELEASE) || (state_nxt == SAMPLE);

    // FSM state, counters and registered control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            phase_cnt  <= '0;
            trial_cnt  <= '0;
            cell_s     <= '0;
            cell_r     <= '0;
            busy       <= 1'b0;
            resp       <= '0;
            resp_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            phase_cnt <= phase_nxt;
            trial_cnt <= trial_nxt;
            cell_s    <= {N{drive_sr}};
            cell_r    <= {N{drive_sr}};
            busy      <= (state_nxt != IDLE);
            if (last_sample) begin
                resp       <= majority_bits;
                resp_valid <= 1'b1;
            end else if (handshake) begin
                resp_valid <= 1'b0;
            end else begin
                resp_valid <= resp_valid;
            end
        end
    end

    // Two-flop synchroniser on the asynchronous latch outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < SYNC_DEPTH; d++) begin
                sync_q[d] <= '0;
            end
        end else begin
            sync_q[0] <= cell_q;
            for (int d = 1; d < SYNC_DEPTH; d++) begin
                sync_q[d] <= sync_q[d-1];
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_cell
        puf_vote_counter #(
            .TRIALS (TRIALS)
        ) u_vote (
            .clk        (clk),
            .rst        (rst),
            .clear      (clear_votes),
            .inc_en     (inc_votes),
            .sample_bit (sync_q[SYNC_DEPTH-1][i]),
            .count      (vote_count_unused[i]),
            .majority   (majority_bits[i])
`ifdef PUF_STABILITY_FLAG_EN
            ,.unanimous (unanimous_bits[i])
`endif
        );
    end

`ifdef PUF_STABILITY_FLAG_EN
    // Unanimity flags: captured with resp, cleared when the response is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable <= '0;
        end else if (last_sample) begin
            stable <= unanimous_bits;
        end else if (handshake) begin
            stable <= '0;
        end else begin
            stable <= stable;
        end
    end
`endif

endmodule

// File: tb/tb_sr_puf_sampler.sv
// -----------------------------------------------------------------------------
// tb_sr_puf_sampler
//   Directed bench for sr_puf_sampler at N=4, TRIALS=5, RST_CYC=2,
//   SETTLE_CYC=4. A behavioural latch model drives cell_q: Q=1 while S is low,
//   and on each release it resolves to the next entry of a per-run pattern.
// -----------------------------------------------------------------------------
module tb_sr_puf_sampler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       resp_ready = 1'b0;
    logic       busy;
    logic [3:0] cell_s;
    logic [3:0] cell_r;
    logic [3:0] cell_q = 4'hF;
    logic [3:0] resp;
    logic       resp_valid;
`ifdef PUF_STABILITY_FLAG_EN
    logic [3:0] stable;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] pat [5];
    int rel_count = 0;
    int rel_base = 0;

    always #5 clk = ~clk;

    sr_puf_sampler #(
        .N          (4),
        .TRIALS     (5),
        .RST_CYC    (2),
        .SETTLE_CYC (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .cell_s     (cell_s),
        .cell_r     (cell_r),
        .cell_q     (cell_q),
        .resp       (resp),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready)
`ifdef PUF_STABILITY_FLAG_EN
        , .stable   (stable)
`endif
    );

    // Latch model: forced to 1 while S is low, resolves on the release edge.
    always @(cell_s) begin : latch_model
        int idx;
        if (cell_s === 4'hF) begin
            idx = rel_count - rel_base;
            if (idx > 4) idx = 4;
            if (idx < 0) idx = 0;
            cell_q = pat[idx];
            rel_count = rel_count + 1;
        end else begin
            cell_q = 4'hF;
        end
    end

    task automatic set_pattern(input logic [3:0] p0, input logic [3:0] p1,
                               input logic [3:0] p2, input logic [3:0] p3,
                               input logic [3:0] p4);
        pat[0] = p0; pat[1] = p1; pat[2] = p2; pat[3] = p3; pat[4] = p4;
        rel_base = rel_count;
    endtask

    // Leaves the bench just after the accepting edge (edge 0 of the run).
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int cycles);
        cycles = 0;
        while (resp_valid !== 1'b1 && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if ({busy, cell_s, cell_r, resp, resp_valid} !== 14'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy=%b s=%b r=%b resp=%b valid=%b, expected all 0",
                     busy, cell_s, cell_r, resp, resp_valid);
        end
`ifdef PUF_STABILITY_FLAG_EN
        vectors++;
        if (stable !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_stable: got %b, expected 0000", stable);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Fixed response, latency, and per-cycle S/R phase sequence.
    task automatic test_fixed_and_phases();
        int bad = 0;
        int first_bad = -1;
        logic [3:0] exp_sr;
        set_pattern(4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010);
        resp_ready = 1'b0;
        pulse_start();
        for (int j = 0; j < 35; j++) begin
            exp_sr = ((j % 7) < 2) ? 4'h0 : 4'hF;
            if (cell_s !== exp_sr || cell_r !== exp_sr || busy !== 1'b1 || resp_valid !== 1'b0) begin
                bad++;
                if (first_bad < 0) first_bad = j;
            end
            @(negedge clk);
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL phase_sequence: %0d bad cycles (first at cycle %0d), expected 0", bad, first_bad);
        end
        vectors++;
        if (resp_valid !== 1'b1 || resp !== 4'b1010 || busy !== 1'b1 || cell_s !== 4'h0 || cell_r !== 4'h0) begin
            miscompares++;
            $display("FAIL fixed_resp_at_36: got valid=%b resp=%b busy=%b s=%b r=%b, expected 1 1010 1 0000 0000",
                     resp_valid, resp, busy, cell_s, cell_r);
        end
`ifdef PUF_STABILITY_FLAG_EN
        vectors++;
        if (stable !== 4'b1111) begin
            miscompares++;
            $display("FAIL fixed_stable: got %b, expected 1111", stable);
        end
`endif
        @(negedge clk);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        vectors++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL fixed_handshake: got valid=%b busy=%b, expected 0 0", resp_valid, busy);
        end
    endtask

    task automatic test_majority();
        int cyc;
        resp_ready = 1'b1;
        // cell0: 1,0,1,0,1 ; cells 3..1 constant 110
        set_pattern(4'b1101, 4'b1100, 4'b1101, 4'b1100, 4'b1101);
        pulse_start();
        wait_valid(60, cyc);
        vectors++;
        if (resp_valid !== 1'b1 || resp !== 4'b1101) begin
            miscompares++;
            $display("FAIL majority_10101: got valid=%b resp=%b, expected 1 1101", resp_valid, resp);
        end
`ifdef PUF_STABILITY_FLAG_EN
        vectors++;
        if (stable !== 4'b1110) begin
            miscompares++;
            $display("FAIL stable_10101: got %b, expected 1110", stable);
        end
`endif
        // cell0: 0,0,1,1,0
        set_pattern(4'b1100, 4'b1100, 4'b1101, 4'b1101, 4'b1100);
        pulse_start();
        wait_valid(60, cyc);
        vectors++;
        if (resp_valid !== 1'b1 || resp !== 4'b1100) begin
            miscompares++;
            $display("FAIL majority_00110: got valid=%b resp=%b, expected 1 1100", resp_valid, resp);
        end
`ifdef PUF_STABILITY_FLAG_EN
        vectors++;
        if (stable !== 4'b1110) begin
            miscompares++;
            $display("FAIL stable_00110: got %b, expected 1110", stable);
        end
`endif
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int cyc;
        int bad = 0;
        set_pattern(4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0110);
        resp_ready = 1'b0;
        pulse_start();
        wait_valid(60, cyc);
        for (int k = 0; k < 10; k++) begin
            start = (k == 3) ? 1'b1 : 1'b0;
            if (resp_valid !== 1'b1 || resp !== 4'b0110 || busy !== 1'b1) bad++;
`ifdef PUF_STABILITY_FLAG_EN
            if (stable !== 4'b1111) bad++;
`endif
            @(negedge clk);
        end
        start = 1'b0;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL backpressure_hold: %0d bad cycles, expected 0", bad);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        vectors++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL backpressure_release: got valid=%b busy=%b, expected 0 0", resp_valid, busy);
        end
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || cell_s !== 4'h0) begin
            miscompares++;
            $display("FAIL start_not_queued: got busy=%b s=%b, expected 0 0000", busy, cell_s);
        end
    endtask

    task automatic test_async_reset();
        int cyc;
        resp_ready = 1'b1;
        set_pattern(4'hF, 4'hF, 4'hF, 4'hF, 4'hF);
        pulse_start();
        repeat (24) @(negedge clk);
        vectors++;
        if (cell_s !== 4'hF || cell_r !== 4'hF || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL in_release_trial3: got s=%b r=%b busy=%b, expected 1111 1111 1", cell_s, cell_r, busy);
        end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if ({busy, cell_s, cell_r, resp, resp_valid} !== 14'd0) begin
            miscompares++;
            $display("FAIL async_reset: got busy=%b s=%b r=%b resp=%b valid=%b, expected all 0",
                     busy, cell_s, cell_r, resp, resp_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        // Two ones only: stale votes from the aborted run would flip the majority.
        set_pattern(4'h0, 4'h0, 4'hF, 4'hF, 4'h0);
        pulse_start();
        wait_valid(60, cyc);
        vectors++;
        if (cyc != 35 || resp_valid !== 1'b1 || resp !== 4'b0000) begin
            miscompares++;
            $display("FAIL post_reset_run: got latency=%0d valid=%b resp=%b, expected 36 1 0000",
                     cyc + 1, resp_valid, resp);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int t = 0;
        int rises [$];
        int idle_between = 0;
        int bad_resp = 0;
        logic prev_valid = 1'b0;
        set_pattern(4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011);
        resp_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < 130; k++) begin
            @(negedge clk);
            t++;
            if (resp_valid === 1'b1 && prev_valid !== 1'b1) begin
                rises.push_back(t);
                if (resp !== 4'b0011) bad_resp++;
            end
            if (rises.size() == 1 && busy === 1'b0) idle_between++;
            prev_valid = resp_valid;
        end
        start = 1'b0;
        vectors++;
        if (rises.size() < 3) begin
            miscompares++;
            $display("FAIL b2b_runs: got %0d valid pulses, expected at least 3", rises.size());
        end else begin
            vectors++;
            if ((rises[1] - rises[0]) != 37 || (rises[2] - rises[1]) != 37) begin
                miscompares++;
                $display("FAIL b2b_period: got %0d and %0d, expected 37 and 37",
                         rises[1] - rises[0], rises[2] - rises[1]);
            end
        end
        vectors++;
        if (idle_between != 1 || bad_resp != 0) begin
            miscompares++;
            $display("FAIL b2b_idle: got idle=%0d bad_resp=%0d, expected 1 0", idle_between, bad_resp);
        end
        repeat (45) @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_drain: got busy=%b, expected 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_fixed_and_phases();
        test_majority();
        test_backpressure();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
